// File: rtl/tag_anc_pkg.sv
// Shared definitions for the tag-chip TX controller: state encoding, GPIO bit map and GAP length.
package tag_anc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_TX   = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_e;

  localparam int GPIO_SYNC_BIT   = 0;
  localparam int GPIO_ACTIVE_BIT = 1;
  localparam int GPIO_READY_BIT  = 2;
  // Bits 0 and 1 drive the tag chip; everything else is an input.
  localparam int GPIO_DDR_MASK   = 3;

  localparam int GAP_LEN = 16;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tag_sync_gen.sv
// SYNC-phase timer: counts cycles while enabled, clears on request, flags the last SYNC cycle.
module tag_sync_gen #(
  parameter int CNT_W  = 16,
  parameter int SYNC_N = 8192
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             done_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYNC_N - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign done_o  = en_i && (count_q == LAST);

endmodule

// File: rtl/tag_tx_ctrl_tag_chip.sv
// TX burst controller for the tag chip: IDLE -> SYNC -> TX -> GAP, aborting when chip ready drops.
// Build option: define TAG_TX_ZERO_PAD_EN to emit zero samples on starved TX cycles instead of stalling.
module tag_tx_ctrl_tag_chip
  import tag_anc_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int GPIO_REG_WIDTH = 12,
  parameter int SYNC_SIG_N     = 8192,
  parameter int TX_LEN         = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tx_en,
  input  logic [DATA_WIDTH-1:0]     itx_in,
  input  logic [DATA_WIDTH-1:0]     qtx_in,
  input  logic                      tx_in_valid,
  output logic                      tx_in_ready,
  output logic [DATA_WIDTH-1:0]     itx_out,
  output logic [DATA_WIDTH-1:0]     qtx_out,
  output logic                      tx_valid,
  output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
  output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
  input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
  output logic [1:0]                tx_state,
  output logic [DATA_WIDTH-1:0]     counter_sync
);

`ifdef TAG_TX_ZERO_PAD_EN
  localparam logic PAD_EN = 1'b1;
`else
  localparam logic PAD_EN = 1'b0;
`endif

  localparam int              SC_W      = cnt_width(TX_LEN);
  localparam logic [SC_W-1:0] SAMP_LAST = SC_W'(TX_LEN - 1);
  localparam int              GC_W      = cnt_width(GAP_LEN);
  localparam logic [GC_W-1:0] GAP_LAST  = GC_W'(GAP_LEN - 1);

  tx_state_e                 state_q, state_d;
  logic [SC_W-1:0]           samp_cnt_q, samp_cnt_d;
  logic [GC_W-1:0]           gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0]     itx_q, itx_d, qtx_q, qtx_d;
  logic                      tx_valid_q, tx_valid_d;
  logic                      ready_q, ready_d;
  logic [GPIO_REG_WIDTH-1:0] gpio_q, gpio_d;

  logic chip_ready, go_burst, sync_clear, sync_en, sync_done;
  logic unused_gpio_in;

  assign chip_ready     = fp_gpio_in[GPIO_READY_BIT];
  assign go_burst       = tx_en && chip_ready;
  assign unused_gpio_in = ^fp_gpio_in;

  // Counter restarts on every SYNC entry and advances on every cycle spent in SYNC.
  assign sync_clear = (state_d == ST_SYNC) && (state_q != ST_SYNC);
  assign sync_en    = (state_q == ST_SYNC);

  tag_sync_gen #(
    .CNT_W  (DATA_WIDTH),
    .SYNC_N (SYNC_SIG_N)
  ) u_sync_gen (
    .clk     (clk),
    .reset   (reset),
    .clear_i (sync_clear),
    .en_i    (sync_en),
    .count_o (counter_sync),
    .done_o  (sync_done)
  );

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    itx_d      = '0;
    qtx_d      = '0;
    tx_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go_burst) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!chip_ready) begin
          state_d = ST_IDLE;
        end else if (sync_done) begin
          state_d    = ST_TX;
          samp_cnt_d = '0;
        end
      end
      ST_TX: begin
        // Losing chip ready wins over a concurrent transfer: the burst is discarded.
        if (!chip_ready) begin
          state_d = ST_IDLE;
        end else if (tx_in_valid) begin
          itx_d      = itx_in;
          qtx_d      = qtx_in;
          tx_valid_d = 1'b1;
          samp_cnt_d = samp_cnt_q + SC_W'(1);
          if (samp_cnt_q == SAMP_LAST) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end
        end else begin
          tx_valid_d = PAD_EN;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = go_burst ? ST_SYNC : ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d                 = (state_d == ST_TX);
    gpio_d                  = '0;
    gpio_d[GPIO_SYNC_BIT]   = (state_d == ST_SYNC);
    gpio_d[GPIO_ACTIVE_BIT] = (state_d == ST_TX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      samp_cnt_q <= '0;
      gap_cnt_q  <= '0;
      itx_q      <= '0;
      qtx_q      <= '0;
      tx_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      gpio_q     <= '0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      itx_q      <= itx_d;
      qtx_q      <= qtx_d;
      tx_valid_q <= tx_valid_d;
      ready_q    <= ready_d;
      gpio_q     <= gpio_d;
    end
  end

  assign tx_state    = state_q;
  assign tx_in_ready = ready_q;
  assign itx_out     = itx_q;
  assign qtx_out     = qtx_q;
  assign tx_valid    = tx_valid_q;
  assign fp_gpio_out = gpio_q;
  assign fp_gpio_ddr = GPIO_REG_WIDTH'(GPIO_DDR_MASK);

endmodule

// File: tb/tb_tag_tx_ctrl_tag_chip.sv
// Self-checking bench for tag_tx_ctrl_tag_chip: burst timeline, abort, not-ready, tx_en drop and random starvation.
module tb_tag_tx_ctrl_tag_chip;

  localparam int DW   = 16;
  localparam int GW   = 12;
  localparam int SN   = 40;
  localparam int TL   = 24;
  localparam int GAPN = 16;
  localparam int P    = SN + TL + GAPN;

`ifdef TAG_TX_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tx_en = 1'b0;
  logic          tx_in_valid = 1'b0;
  logic          tx_in_ready, tx_valid;
  logic [DW-1:0] itx_in = '0, qtx_in = '0;
  logic [DW-1:0] itx_out, qtx_out, counter_sync;
  logic [GW-1:0] fp_gpio_out, fp_gpio_ddr;
  logic [GW-1:0] fp_gpio_in = '0;
  logic [1:0]    tx_state;

  int n_assert = 0;
  int n_fail   = 0;
  bit rand_mode = 1'b0;
  int accepted = 0, outs = 0, rdy_cycles = 0;
  int acc0 = 0, out0 = 0, rdy0 = 0, bursts = 0;
  logic [1:0] prev_state = 2'd0;

  always #5 clk = ~clk;

  tag_tx_ctrl_tag_chip #(
    .DATA_WIDTH     (DW),
    .GPIO_REG_WIDTH (GW),
    .SYNC_SIG_N     (SN),
    .TX_LEN         (TL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_en        (tx_en),
    .itx_in       (itx_in),
    .qtx_in       (qtx_in),
    .tx_in_valid  (tx_in_valid),
    .tx_in_ready  (tx_in_ready),
    .itx_out      (itx_out),
    .qtx_out      (qtx_out),
    .tx_valid     (tx_valid),
    .fp_gpio_out  (fp_gpio_out),
    .fp_gpio_ddr  (fp_gpio_ddr),
    .fp_gpio_in   (fp_gpio_in),
    .tx_state     (tx_state),
    .counter_sync (counter_sync)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: optional random stimulus, then the one-cycle handshake rule checked on tx_valid/data.
  task automatic tick();
    bit acc, pad_c;
    logic [DW-1:0] ei, eq;
    if (rand_mode) begin
      tx_in_valid = 1'($urandom_range(0, 1));
      itx_in      = DW'($urandom);
      qtx_in      = DW'($urandom);
    end
    acc   = reset && fp_gpio_in[2] && tx_in_ready && tx_in_valid;
    pad_c = PAD && reset && fp_gpio_in[2] && tx_in_ready && !acc;
    ei    = acc ? itx_in : '0;
    eq    = acc ? qtx_in : '0;
    if (reset && fp_gpio_in[2] && tx_in_ready) rdy_cycles++;
    @(posedge clk);
    #1;
    chk("tx_valid", 32'(acc || pad_c), 32'(tx_valid));
    if (acc || pad_c) begin
      chk("itx_out", 32'(itx_out), 32'(ei));
      chk("qtx_out", 32'(qtx_out), 32'(eq));
    end
    if (acc) accepted++;
    if (tx_valid) outs++;
  endtask

  // Expected timeline for an uninterrupted, never-starved run, u cycles after the start edge.
  task automatic sched(input int u, input bit rep);
    int v, ec;
    logic [1:0] es;
    logic [GW-1:0] eg;
    bit er, ev;
    if (!rep && u >= P) begin
      es = 2'd0; eg = '0; ec = SN; er = 1'b0; ev = 1'b0;
    end else begin
      v = u % P;
      if (v < SN) begin
        es = 2'd1; eg = GW'(1); ec = v; er = 1'b0; ev = 1'b0;
      end else if (v < SN + TL) begin
        es = 2'd2; eg = GW'(2); ec = SN; er = 1'b1; ev = (v > SN);
      end else begin
        es = 2'd3; eg = '0; ec = SN; er = 1'b0; ev = (v == SN + TL);
      end
    end
    chk("sched_state", 32'(tx_state), 32'(es));
    chk("sched_gpio_out", 32'(fp_gpio_out), 32'(eg));
    chk("sched_counter_sync", 32'(counter_sync), 32'(ec));
    chk("sched_ready", 32'(tx_in_ready), 32'(er));
    chk("sched_valid", 32'(tx_valid), 32'(ev));
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    tx_en       = 1'b0;
    tx_in_valid = 1'b0;
    fp_gpio_in  = '0;
    rand_mode   = 1'b0;
    itx_in      = '0;
    qtx_in      = '0;
    #1;
    chk("rst_state", 32'(tx_state), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_ready", 32'(tx_in_ready), 32'd0);
    chk("rst_itx", 32'(itx_out), 32'd0);
    chk("rst_qtx", 32'(qtx_out), 32'd0);
    chk("rst_gpio_out", 32'(fp_gpio_out), 32'd0);
    chk("rst_counter_sync", 32'(counter_sync), 32'd0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic burst_mon();
    if (tx_state == 2'd3 && prev_state != 2'd3) begin
      chk("burst_accepted", 32'(accepted - acc0), 32'(TL));
      chk("burst_outputs", 32'(outs - out0), PAD ? 32'(rdy_cycles - rdy0) : 32'(TL));
      $display("burst %0d: accepted=%0d outputs=%0d", bursts, accepted - acc0, outs - out0);
      acc0 = accepted;
      out0 = outs;
      rdy0 = rdy_cycles;
      bursts++;
    end
    prev_state = tx_state;
  endtask

  initial begin
    #2;
    do_reset();
    chk("gpio_ddr", 32'(fp_gpio_ddr), 32'h003);

    // Chip not ready: stay in IDLE with the counter untouched.
    tx_en      = 1'b1;
    fp_gpio_in = GW'(12'h040);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("notready_state", 32'(tx_state), 32'd0);
      chk("notready_counter", 32'(counter_sync), 32'd0);
      chk("notready_gpio", 32'(fp_gpio_out), 32'd0);
    end

    // Nominal: constant samples, two full bursts, then reset in the middle of the third TX.
    do_reset();
    tx_en       = 1'b1;
    fp_gpio_in  = GW'(12'h004);
    tx_in_valid = 1'b1;
    itx_in      = DW'(16000);
    qtx_in      = DW'(-16000);
    for (int u = 0; u < 2 * P + SN + 8; u++) begin
      tick();
      sched(u, 1'b1);
    end
    do_reset();

    // tx_en drops mid-TX: the burst completes, then IDLE after GAP.
    tx_en       = 1'b1;
    fp_gpio_in  = GW'(12'h004);
    tx_in_valid = 1'b1;
    itx_in      = DW'(16'h1234);
    qtx_in      = DW'(16'hABCD);
    for (int u = 0; u < P + 12; u++) begin
      tick();
      sched(u, 1'b0);
      if (u == SN + 5) tx_en = 1'b0;
    end

    // Abort during TX at sample 10, then abort during SYNC.
    do_reset();
    tx_en       = 1'b1;
    fp_gpio_in  = GW'(12'h004);
    tx_in_valid = 1'b1;
    itx_in      = DW'(16'h0F0F);
    qtx_in      = DW'(16'hF0F0);
    for (int u = 0; u <= SN + 10; u++) begin
      tick();
      sched(u, 1'b1);
    end
    fp_gpio_in = '0;
    tick();
    chk("abort_tx_state", 32'(tx_state), 32'd0);
    chk("abort_tx_gpio", 32'(fp_gpio_out), 32'd0);
    chk("abort_tx_ready", 32'(tx_in_ready), 32'd0);
    chk("abort_tx_itx", 32'(itx_out), 32'd0);
    chk("abort_tx_qtx", 32'(qtx_out), 32'd0);
    chk("abort_tx_counter", 32'(counter_sync), 32'(SN));
    fp_gpio_in = GW'(12'h004);
    tick();
    chk("resync_state", 32'(tx_state), 32'd1);
    chk("resync_counter", 32'(counter_sync), 32'd0);
    repeat (4) tick();
    fp_gpio_in = '0;
    tick();
    chk("abort_sync_state", 32'(tx_state), 32'd0);
    chk("abort_sync_gpio", 32'(fp_gpio_out), 32'd0);

    // Random starvation: every burst must carry exactly TL accepted samples.
    do_reset();
    tx_en      = 1'b1;
    fp_gpio_in = GW'(12'h004);
    rand_mode  = 1'b1;
    acc0 = accepted; out0 = outs; rdy0 = rdy_cycles; bursts = 0; prev_state = tx_state;
    for (int c = 0; c < 3000 && bursts < 2; c++) begin
      tick();
      burst_mon();
    end
    chk("starve_bursts_done", 32'(bursts), 32'd2);
    tx_en = 1'b0;
    for (int c = 0; c < 600 && tx_state != 2'd0; c++) begin
      tick();
      burst_mon();
    end
    chk("starve_final_idle", 32'(tx_state), 32'd0);
    rand_mode = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
